branch_resolve_unit: RTL and testbench

//  Consumes the 3-bit status vector produced by the 16-bit ALU ({N,V,Z} = status[2:0]).

---
 rtl/branch_resolve_unit.sv | 182 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: holds the ALU status register ({N,V,Z}) and resolves
// conditional branches into a next-PC value plus a one-cycle PC-load strobe,
// using a request/done handshake with the datapath controller.
// Optional feature macro: BRU_LINK_EN (adds BL and link_we/link_val outputs).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for br_req; operands and flags captured on acceptance
// EVAL   | condition and next PC computed from captured operands
// COMMIT | pc_load/br_done/taken asserted for this single cycle
module branch_resolve_unit #(
   parameter int PC_WIDTH   = 9,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_s,
   input  logic [2:0]            status_in,
   input  logic                  br_req,
   input  logic [2:0]            br_cond,
   input  logic [PC_WIDTH-1:0]   pc_in,
   input  logic [DATA_WIDTH-1:0] sximm8,
   output logic [2:0]            status_out,
   output logic [PC_WIDTH-1:0]   pc_out,
   output logic                  pc_load,
   output logic                  taken,
   output logic                  busy,
`ifdef BRU_LINK_EN
   output logic                  link_we,
   output logic [PC_WIDTH-1:0]   link_val,
`endif
   output logic                  br_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [2:0] COND_B   = 3'b000;
   localparam logic [2:0] COND_BEQ = 3'b001;
   localparam logic [2:0] COND_BNE = 3'b010;
   localparam logic [2:0] COND_BLT = 3'b011;
   localparam logic [2:0] COND_BLE = 3'b100;
`ifdef BRU_LINK_EN
   localparam logic [2:0] COND_BL  = 3'b101;
`endif

   state_t              state_q, state_d;
   logic [2:0]          status_q, status_d;
   logic [2:0]          flags_q, flags_d;
   logic [2:0]          cond_q, cond_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] off_q, off_d;
   logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
   logic                pc_load_q, pc_load_d;
   logic                taken_q, taken_d;
`ifdef BRU_LINK_EN
   logic                link_we_q, link_we_d;
   logic [PC_WIDTH-1:0] link_val_q, link_val_d;
`endif

   logic                cond_true;
   logic [PC_WIDTH-1:0] pc_plus1;

   // Only the low PC_WIDTH offset bits matter; the rest are sign copies.
   logic                unused_sximm8_hi;
   assign unused_sximm8_hi = ^sximm8[DATA_WIDTH-1:PC_WIDTH];

   // Condition decode from the flags captured when the branch was accepted.
   always_comb begin
      cond_true = 1'b0;
      case (cond_q)
         COND_B:   cond_true = 1'b1;
         COND_BEQ: cond_true = flags_q[0];
         COND_BNE: cond_true = ~flags_q[0];
         COND_BLT: cond_true = flags_q[2] ^ flags_q[1];
         COND_BLE: cond_true = (flags_q[2] ^ flags_q[1]) | flags_q[0];
`ifdef BRU_LINK_EN
         COND_BL:  cond_true = 1'b1;
`endif
         default:  cond_true = 1'b0;
      endcase
   end

   assign pc_plus1 = pc_q + PC_WIDTH'(1);

   // Next-state, operand capture and registered output values.
   always_comb begin
      state_d    = state_q;
      status_d   = status_q;
      flags_d    = flags_q;
      cond_d     = cond_q;
      pc_d       = pc_q;
      off_d      = off_q;
      pc_out_d   = pc_out_q;
      pc_load_d  = 1'b0;
      taken_d    = 1'b0;
`ifdef BRU_LINK_EN
      link_we_d  = 1'b0;
      link_val_d = link_val_q;
`endif

      if (load_s)
         status_d = status_in;

      case (state_q)
         IDLE: begin
            if (br_req) begin
               // Flags are the register contents before any same-edge load.
               flags_d = status_q;
               cond_d  = br_cond;
               pc_d    = pc_in;
               off_d   = sximm8[PC_WIDTH-1:0];
               state_d = EVAL;
            end
         end
         EVAL: begin
            pc_load_d = 1'b1;
            taken_d   = cond_true;
            pc_out_d  = cond_true ? (pc_plus1 + off_q) : pc_plus1;
`ifdef BRU_LINK_EN
            link_we_d  = (cond_q == COND_BL);
            link_val_d = (cond_q == COND_BL) ? pc_plus1 : link_val_q;
`endif
            state_d   = COMMIT;
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         status_q   <= 3'b000;
         flags_q    <= 3'b000;
         cond_q     <= 3'b000;
         pc_q       <= '0;
         off_q      <= '0;
         pc_out_q   <= '0;
         pc_load_q  <= 1'b0;
         taken_q    <= 1'b0;
`ifdef BRU_LINK_EN
         link_we_q  <= 1'b0;
         link_val_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         status_q   <= status_d;
         flags_q    <= flags_d;
         cond_q     <= cond_d;
         pc_q       <= pc_d;
         off_q      <= off_d;
         pc_out_q   <= pc_out_d;
         pc_load_q  <= pc_load_d;
         taken_q    <= taken_d;
`ifdef BRU_LINK_EN
         link_we_q  <= link_we_d;
         link_val_q <= link_val_d;
`endif
      end
   end

   assign status_out = status_q;
   assign pc_out     = pc_out_q;
   assign pc_load    = pc_load_q;
   assign br_done    = pc_load_q;
   assign taken      = taken_q;
   assign busy       = (state_q != IDLE);
`ifdef BRU_LINK_EN
   assign link_we    = link_we_q;
   assign link_val   = link_val_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit; works with or without BRU_LINK_EN.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_s;
   logic [2:0]  status_in;
   logic        br_req;
   logic [2:0]  br_cond;
   logic [8:0]  pc_in;
   logic [15:0] sximm8;
   logic [2:0]  status_out;
   logic [8:0]  pc_out;
   logic        pc_load;
   logic        taken;
   logic        busy;
   logic        br_done;
`ifdef BRU_LINK_EN
   logic        link_we;
   logic [8:0]  link_val;
`endif

   int checks   = 0;
   int failures = 0;

   branch_resolve_unit #(.PC_WIDTH(9), .DATA_WIDTH(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_s     (load_s),
      .status_in  (status_in),
      .br_req     (br_req),
      .br_cond    (br_cond),
      .pc_in      (pc_in),
      .sximm8     (sximm8),
      .status_out (status_out),
      .pc_out     (pc_out),
      .pc_load    (pc_load),
      .taken      (taken),
      .busy       (busy),
`ifdef BRU_LINK_EN
      .link_we    (link_we),
      .link_val   (link_val),
`endif
      .br_done    (br_done)
   );

   always #5 clk = ~clk;

   task automatic set_status(input logic [2:0] s);
      @(negedge clk);
      load_s    = 1'b1;
      status_in = s;
      @(negedge clk);
      load_s    = 1'b0;
   endtask

   // Issues one branch and waits (bounded) for pc_load; returns what was seen.
   task automatic do_branch(input logic [2:0] c, input logic [8:0] pc, input logic [15:0] imm,
                            output int lat, output logic got, output logic tk,
                            output logic [8:0] po, output logic dn);
      @(negedge clk);
      br_req  = 1'b1;
      br_cond = c;
      pc_in   = pc;
      sximm8  = imm;
      @(negedge clk);
      br_req = 1'b0;
      lat = 1;
      while (!pc_load && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      got = pc_load;
      tk  = taken;
      po  = pc_out;
      dn  = br_done;
   endtask

   task automatic test_reset;
      reset = 1'b1; load_s = 1'b0; status_in = 3'b000; br_req = 1'b0;
      br_cond = 3'b000; pc_in = '0; sximm8 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({status_out, pc_out, pc_load, taken, busy, br_done} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs: got st=%b pc=%h ld=%b tk=%b busy=%b dn=%b, want all 0",
                  status_out, pc_out, pc_load, taken, busy, br_done);
      end
`ifdef BRU_LINK_EN
      checks++;
      if (link_we !== 1'b0 || link_val !== 9'h000) begin
         failures++;
         $display("FAIL reset_link: got we=%b val=%h want 0/000", link_we, link_val);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_beq_taken;
      int lat; logic got, tk, dn; logic [8:0] po;
      set_status(3'b001);
      checks++;
      if (status_out !== 3'b001) begin
         failures++; $display("FAIL status_load: got %b want 001", status_out);
      end
      do_branch(3'b001, 9'd10, 16'd5, lat, got, tk, po, dn);
      checks++;
      if (!got || lat != 2) begin
         failures++; $display("FAIL beq_latency: got load=%b lat=%0d want 1/2", got, lat);
      end
      checks++;
      if (tk !== 1'b1 || po !== 9'd16 || dn !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL beq_taken: got tk=%b pc=%0d dn=%b busy=%b want 1/16/1/1", tk, po, dn, busy);
      end
      @(negedge clk);
      checks++;
      if (pc_load !== 1'b0 || br_done !== 1'b0 || busy !== 1'b0 || pc_out !== 9'd16) begin
         failures++;
         $display("FAIL after_commit: got ld=%b dn=%b busy=%b pc=%0d want 0/0/0/16",
                  pc_load, br_done, busy, pc_out);
      end
   endtask

   task automatic test_beq_bne;
      int lat; logic got, tk, dn; logic [8:0] po;
      set_status(3'b000);
      do_branch(3'b001, 9'd10, 16'd5, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b0 || po !== 9'd11) begin
         failures++; $display("FAIL beq_not_taken: got ld=%b tk=%b pc=%0d want 1/0/11", got, tk, po);
      end
      do_branch(3'b010, 9'd10, 16'd5, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b1 || po !== 9'd16) begin
         failures++; $display("FAIL bne_taken: got ld=%b tk=%b pc=%0d want 1/1/16", got, tk, po);
      end
   endtask

   task automatic test_blt_ble;
      int lat; logic got, tk, dn; logic [8:0] po;
      set_status(3'b100);
      do_branch(3'b011, 9'd20, 16'hFFFC, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b1 || po !== 9'd17) begin
         failures++; $display("FAIL blt_taken: got ld=%b tk=%b pc=%0d want 1/1/17", got, tk, po);
      end
      set_status(3'b110);
      do_branch(3'b011, 9'd20, 16'hFFFC, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b0 || po !== 9'd21) begin
         failures++; $display("FAIL blt_not_taken: got ld=%b tk=%b pc=%0d want 1/0/21", got, tk, po);
      end
      do_branch(3'b100, 9'd40, 16'd8, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b0 || po !== 9'd41) begin
         failures++; $display("FAIL ble_not_taken: got ld=%b tk=%b pc=%0d want 1/0/41", got, tk, po);
      end
      set_status(3'b111);
      do_branch(3'b100, 9'd40, 16'd8, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b1 || po !== 9'd49) begin
         failures++; $display("FAIL ble_z_taken: got ld=%b tk=%b pc=%0d want 1/1/49", got, tk, po);
      end
   endtask

   task automatic test_wrap_reserved;
      int lat; logic got, tk, dn; logic [8:0] po;
      logic exp_bl;
      do_branch(3'b000, 9'h1FF, 16'd1, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b1 || po !== 9'h001) begin
         failures++; $display("FAIL b_wrap: got ld=%b tk=%b pc=%h want 1/1/001", got, tk, po);
      end
      do_branch(3'b111, 9'h1FF, 16'd1, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b0 || po !== 9'h000) begin
         failures++; $display("FAIL reserved_111: got ld=%b tk=%b pc=%h want 1/0/000", got, tk, po);
      end
      do_branch(3'b110, 9'd50, 16'd4, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== 1'b0 || po !== 9'd51) begin
         failures++; $display("FAIL reserved_110: got ld=%b tk=%b pc=%0d want 1/0/51", got, tk, po);
      end
`ifdef BRU_LINK_EN
      exp_bl = 1'b1;
`else
      exp_bl = 1'b0;
`endif
      do_branch(3'b101, 9'd30, 16'd16, lat, got, tk, po, dn);
      checks++;
      if (!got || tk !== exp_bl || po !== (exp_bl ? 9'd47 : 9'd31)) begin
         failures++; $display("FAIL code_101: got ld=%b tk=%b pc=%0d want tk=%b", got, tk, po, exp_bl);
      end
`ifdef BRU_LINK_EN
      checks++;
      if (link_we !== 1'b1 || link_val !== 9'd31) begin
         failures++; $display("FAIL bl_link: got we=%b val=%0d want 1/31", link_we, link_val);
      end
`endif
   endtask

   task automatic test_same_edge_and_ignore;
      int dones = 0;
      logic tk_seen = 1'bx;
      logic [8:0] pc_seen = 'x;
      set_status(3'b000);
      @(negedge clk);
      br_req = 1'b1; br_cond = 3'b001; pc_in = 9'd10; sximm8 = 16'd5;
      load_s = 1'b1; status_in = 3'b001;
      @(negedge clk);
      load_s = 1'b0;
      pc_in  = 9'd100;
      @(negedge clk);
      br_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (br_done) begin
            dones++; tk_seen = taken; pc_seen = pc_out;
         end
         @(negedge clk);
      end
      checks++;
      if (dones != 1) begin
         failures++; $display("FAIL single_done: got %0d br_done pulses want 1", dones);
      end
      checks++;
      if (tk_seen !== 1'b0 || pc_seen !== 9'd11 || status_out !== 3'b001) begin
         failures++;
         $display("FAIL old_flags: got tk=%b pc=%0d st=%b want 0/11/001", tk_seen, pc_seen, status_out);
      end
   endtask

   task automatic test_back_to_back;
      int loads[$];
      @(negedge clk);
      br_req = 1'b1; br_cond = 3'b000; pc_in = 9'd100; sximm8 = 16'd3;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (pc_load) loads.push_back(i);
         if (i == 9) br_req = 1'b0;
      end
      checks++;
      if (loads.size() != 3 || loads[0] != 2 || loads[1] != 5 || loads[2] != 8) begin
         failures++;
         $display("FAIL back_to_back: got %0d loads (first at %0d) want 3 at 2,5,8",
                  loads.size(), (loads.size() > 0) ? loads[0] : -1);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (pc_out !== 9'd104 || pc_load !== 1'b0) begin
         failures++; $display("FAIL pc_hold: got pc=%0d ld=%b want 104/0", pc_out, pc_load);
      end
   endtask

   task automatic test_reset_mid_eval;
      int loads = 0;
      set_status(3'b101);
      @(negedge clk);
      br_req = 1'b1; br_cond = 3'b000; pc_in = 9'd7; sximm8 = 16'd1;
      @(negedge clk);
      br_req = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (status_out !== 3'b000 || busy !== 1'b0 || pc_load !== 1'b0) begin
         failures++;
         $display("FAIL reset_eval: got st=%b busy=%b ld=%b want 000/0/0", status_out, busy, pc_load);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (pc_load) loads++;
      end
      checks++;
      if (loads != 0 || pc_out !== 9'd0) begin
         failures++; $display("FAIL reset_abort: got %0d loads pc=%0d want 0/0", loads, pc_out);
      end
   endtask

   initial begin
      test_reset();
      test_beq_taken();
      test_beq_bne();
      test_blt_ble();
      test_wrap_reserved();
      test_same_edge_and_ignore();
      test_back_to_back();
      test_reset_mid_eval();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
